// File: rtl/risc5_memctrl_if.sv
// rtl/risc5_memctrl_if.sv - CPU and SRAM bus bundle for risc5_memctrl
// RISC5_MEMCTRL_IO_BYPASS_EN adds the io_rdata / io_sel pair.
interface risc5_memctrl_if;
  logic [23:0] adr;
  logic        rd;
  logic        wr;
  logic        ben;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        memwait;
  logic [22:0] sram_a;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_we_n;
  logic        sram_lb_n;
  logic        sram_ub_n;
`ifdef RISC5_MEMCTRL_IO_BYPASS_EN
  logic [31:0] io_rdata;
  logic        io_sel;

  modport slave (
    input  adr, rd, wr, ben, wdata, sram_dq_i, io_rdata,
    output rdata, memwait, sram_a, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n, io_sel
  );
  modport master (
    output adr, rd, wr, ben, wdata, sram_dq_i, io_rdata,
    input  rdata, memwait, sram_a, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n, io_sel
  );
`else
  modport slave (
    input  adr, rd, wr, ben, wdata, sram_dq_i,
    output rdata, memwait, sram_a, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n
  );
  modport master (
    output adr, rd, wr, ben, wdata, sram_dq_i,
    input  rdata, memwait, sram_a, sram_dq_o, sram_dq_oe,
           sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n
  );
`endif
endinterface

// File: rtl/risc5_memctrl.sv
// rtl/risc5_memctrl.sv - 32-bit CPU to 16-bit async SRAM controller, two half-word accesses per word
// RISC5_MEMCTRL_IO_BYPASS_EN: top 64 bytes of address space bypass SRAM and return io_rdata.
module risc5_memctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  risc5_memctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LO_SET, LO_STB, HI_SET, HI_STB, DONE} state_t;

  localparam logic [2:0] CNT_RELOAD = 3'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [21:0] adr_q;
  logic        adr0_q;
  logic        rd_q, wr_q, ben_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic byte_acc, in_set, in_stb, in_hi, active, stb_last, io_hit, byte_req;

  assign byte_acc = ben_q & (rd_q | wr_q);
  assign in_set   = (state == LO_SET) || (state == HI_SET);
  assign in_stb   = (state == LO_STB) || (state == HI_STB);
  assign in_hi    = (state == HI_SET) || (state == HI_STB);
  assign active   = in_set | in_stb;
  assign stb_last = in_stb && (cnt == 3'd0);
  // Byte vs. word is decided from the live request while still in IDLE.
  assign byte_req = bus.ben & (bus.rd | bus.wr);

`ifdef RISC5_MEMCTRL_IO_BYPASS_EN
  assign io_hit     = &bus.adr[23:6];
  assign bus.io_sel = (state == IDLE) && io_hit;
`else
  assign io_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (io_hit)
          state_nxt = DONE;
        else if (byte_req && bus.adr[1])
          state_nxt = HI_SET;
        else
          state_nxt = LO_SET;
      end
      LO_SET: state_nxt = LO_STB;
      LO_STB: if (cnt == 3'd0) state_nxt = byte_acc ? DONE : HI_SET;
      HI_SET: state_nxt = HI_STB;
      HI_STB: if (cnt == 3'd0) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      adr_q   <= '0;
      adr0_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ben_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        adr_q   <= bus.adr[23:2];
        adr0_q  <= bus.adr[0];
        rd_q    <= bus.rd;
        wr_q    <= bus.wr;
        ben_q   <= bus.ben;
        wdata_q <= bus.wdata;
`ifdef RISC5_MEMCTRL_IO_BYPASS_EN
        if (io_hit)
          rdata_q <= bus.io_rdata;
`endif
      end
      if (in_set)
        cnt <= CNT_RELOAD;
      else if (in_stb && cnt != 3'd0)
        cnt <= cnt - 3'd1;
      // Byte reads zero the other half so the CPU only has to pick a lane.
      if (stb_last && !wr_q) begin
        if (byte_acc)
          rdata_q <= in_hi ? {bus.sram_dq_i, 16'h0000} : {16'h0000, bus.sram_dq_i};
        else if (in_hi)
          rdata_q[31:16] <= bus.sram_dq_i;
        else
          rdata_q[15:0] <= bus.sram_dq_i;
      end
    end
  end

  assign bus.memwait    = (state != DONE);
  assign bus.rdata      = rdata_q;
  assign bus.sram_a     = {adr_q, in_hi};
  assign bus.sram_dq_o  = in_hi ? wdata_q[31:16] : wdata_q[15:0];
  assign bus.sram_dq_oe = active & wr_q;
  assign bus.sram_ce_n  = ~active;
  assign bus.sram_we_n  = ~(in_stb & wr_q);
  assign bus.sram_lb_n  = active ? (byte_acc & adr0_q)  : 1'b1;
  assign bus.sram_ub_n  = active ? (byte_acc & ~adr0_q) : 1'b1;

endmodule

// File: doc/risc5_memctrl.md
RISC5_MEMCTRL -- requirements
Module: risc5_memctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, strobe cycles per half-word SRAM access, legal range 1..7.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 adr  in  24  CPU byte address, held stable by the CPU while memwait=1.
REQ-005 rd / wr  in  1 / 1  CPU load / store request; neither asserted means instruction fetch.
REQ-006 ben  in  1  byte access qualifier for rd/wr.
REQ-007 wdata  in  32  CPU store data; for byte stores the byte sits in lane adr[1:0].
REQ-008 rdata  out  32  read/fetch word, feeds CPU inbus and codebus.
REQ-009 memwait  out  1  CPU stall; high while an access is incomplete.
REQ-010 sram_a  out  23  half-word address.
REQ-011 sram_dq_o / sram_dq_i / sram_dq_oe  out 16 / in 16 / out 1  SRAM data bus halves and output enable.
REQ-012 sram_ce_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low strobes.

Function
REQ-013 FSM states: IDLE, LO_SET, LO_STB, HI_SET, HI_STB, DONE.
REQ-014 Every cycle is an access: IDLE latches adr/rd/wr/ben/wdata and always moves on; no idle bypass.
REQ-015 memwait = (state != DONE), combinational; DONE lasts exactly 1 cycle, then IDLE.
REQ-016 Word access: IDLE -> LO_SET -> LO_STB (WAIT_CYCLES cycles) -> HI_SET -> HI_STB (WAIT_CYCLES cycles) -> DONE; total 2*WAIT_CYCLES+4 cycles, memwait high 2*WAIT_CYCLES+3.
REQ-017 Byte access (ben with rd or wr): only the half selected by adr[1]; IDLE -> x_SET -> x_STB -> DONE, with x = LO if adr[1]=0 else HI.
REQ-018 sram_a = {adr[23:2], 0} in LO states, {adr[23:2], 1} in HI states; bits 15:0 of the word are the low half.
REQ-019 SET cycle: ce_n=0, we_n=1, address and write data driven; STB cycles: ce_n=0, we_n=0 for writes only.
REQ-020 Word access: lb_n=ub_n=0; byte access: lb_n=adr[0], ub_n=~adr[0].
REQ-021 Writes: dq_oe=1 in SET and STB; dq_o = wdata[15:0] (LO) / wdata[31:16] (HI); reads keep dq_oe=0.
REQ-022 Reads/fetches capture sram_dq_i on the clock edge ending the last STB cycle into the addressed half of an internal word register.
REQ-023 Byte read: the unaccessed half of rdata is 0; the CPU selects the byte lane.
REQ-024 rdata is registered and stable throughout DONE; it is held until the next capture.
REQ-025 In IDLE and DONE: ce_n=we_n=lb_n=ub_n=1, dq_oe=0.
REQ-026 rd and wr both high is illegal; wr takes priority.
REQ-027 The down-counter for STB cycles reloads to WAIT_CYCLES-1 on each SET cycle; STB exits at 0.

Reset
REQ-028 rst in any state forces IDLE on the next edge and discards the request; the counter clears.
REQ-029 Reset values: rdata=0, sram_ce_n=sram_we_n=sram_lb_n=sram_ub_n=1, sram_dq_oe=0, sram_a=0, sram_dq_o=0; memwait=1 (CPU ignores it under rst).
REQ-030 A write interrupted by rst issues no further we_n pulses.

Configuration
REQ-031 Macro RISC5_MEMCTRL_IO_BYPASS_EN.
REQ-032 Defined: adds ports io_rdata in 32 and io_sel out 1; adr[23:6] all ones (adr >= 24'hFFFFC0) goes IDLE -> DONE with no SRAM strobes.
REQ-033 In that case io_sel=1 in IDLE; rdata = io_rdata captured at the end of IDLE; memwait high exactly 1 cycle.
REQ-034 Not defined: no io ports; all addresses access SRAM.

Verification
REQ-035 Fetch adr=24'h000100, SRAM[0x80]=16'h1234, SRAM[0x81]=16'hABCD, WAIT_CYCLES=1 -> memwait high 5 cycles; rdata=32'hABCD1234 in DONE; we_n never low.
REQ-036 Word store adr=24'h000008, wdata=32'hDEADBEEF -> writes a=4 dq=16'hBEEF then a=5 dq=16'hDEAD; lb_n=ub_n=0; one we_n-low cycle each.
REQ-037 Byte store adr=24'h000007, ben, wdata=32'h5A5A5A5A -> single access a=3, dq=16'h5A5A, ub_n=0, lb_n=1; total 4 cycles.
REQ-038 Byte load adr=24'h000002, ben, SRAM[1]=16'h00C3 -> only a=1 strobed; rdata=32'h00C30000.
REQ-039 rst asserted during HI_STB of a word store -> next cycle IDLE, ce_n=we_n=1, dq_oe=0, no further strobes.
REQ-040 Macro defined, load adr=24'hFFFFC4, io_rdata=32'h00000055 -> ce_n stays 1, memwait high 1 cycle, rdata=32'h00000055.
